// File: rtl/shift_pla_act_pipe.sv
// Pipelined shift-and-add piecewise-linear tanh/sigmoid unit.
// Three elastic stages, each with its own valid bit; the mode bit travels with every sample.
module shift_pla_act_pipe #(
    parameter int W_IN     = 10,
    parameter int IN_I     = 4,
    parameter int W_OUT    = 10,
    parameter int OUT_I    = 2,
    parameter int BOUNDARY = 1
) (
    input  logic             clock_i,
    input  logic             resetn_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [W_IN-1:0]  in_data_i,
    input  logic             in_mode_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [W_OUT-1:0] out_data_o,
    output logic             out_sat_o
);
    localparam int FI = W_IN - IN_I;
    localparam int FO = W_OUT - OUT_I;
    localparam int FP = ((FI > FO) ? FI : FO) + 3;
    localparam int AW = W_IN + 1;
    localparam int MW = FP + IN_I + 1;

    localparam logic [AW-1:0] A_SAT  = AW'(1) << (BOUNDARY + FI);
    localparam logic [MW-1:0] M_HALF = MW'(1) << (FP - 1);
    localparam logic [MW-1:0] M_ONE  = MW'(1) << FP;
    localparam logic [MW-1:0] M_QTR  = MW'(1) << (FP - 2);
    localparam logic [MW-1:0] M_OFF3 = MW'(5) << (FP - 3);
    localparam logic [MW-1:0] M_MAX  = MW'((1 << FO) - 1) << (FP - FO);

    logic s1_v_q, s2_v_q, s3_v_q;
    logic s1_v_d, s2_v_d, s3_v_d;
    logic s1_load, s2_load, s3_load;

    // A stage loads when it is empty or its content moves on this cycle.
    assign s3_load    = !s3_v_q || out_ready_i;
    assign s2_load    = !s2_v_q || s3_load;
    assign s1_load    = !s1_v_q || s2_load;
    assign in_ready_o = s1_load;

    always_comb begin
        s1_v_d = s1_load ? in_valid_i : s1_v_q;
        s2_v_d = s2_load ? s1_v_q     : s2_v_q;
        s3_v_d = s3_load ? s2_v_q     : s3_v_q;
    end

    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            s1_v_q <= 1'b0;
            s2_v_q <= 1'b0;
            s3_v_q <= 1'b0;
        end else begin
            s1_v_q <= s1_v_d;
            s2_v_q <= s2_v_d;
            s3_v_q <= s3_v_d;
        end
    end

    // Stage 1: fold to magnitude, one extra bit so the most negative input does not overflow.
    logic signed [W_IN-1:0] t_s;
    logic [AW-1:0]          t_ext, s1_a_d, s1_a_q;
    logic                   s1_sign_q, s1_mode_q, s1_sat_q;

    always_comb begin
        t_s    = in_mode_i ? ($signed(in_data_i) >>> 1) : $signed(in_data_i);
        t_ext  = {t_s[W_IN-1], t_s};
        s1_a_d = t_s[W_IN-1] ? (~t_ext + AW'(1)) : t_ext;
    end

    always_ff @(posedge clock_i) begin
        if (s1_load && in_valid_i) begin
            s1_a_q    <= s1_a_d;
            s1_sign_q <= t_s[W_IN-1];
            s1_mode_q <= in_mode_i;
            s1_sat_q  <= (s1_a_d >= A_SAT);
        end
    end

    // Stage 2: segment select, shift and offset add at FP fractional bits.
    logic [MW-1:0] a_fp, seg3, m_full;
    logic [FP-1:0] s2_m_d, s2_m_q;
    logic          s2_sign_q, s2_mode_q, s2_sat_q;

    always_comb begin
        a_fp = MW'(s1_a_q) << (FP - FI);
        seg3 = (a_fp >> 3) + M_OFF3;
        if (s1_sat_q)
            m_full = M_MAX;
        else if (a_fp < M_HALF)
            m_full = a_fp;
        else if (a_fp < M_ONE)
            m_full = (a_fp >> 1) + M_QTR;
        else if (seg3 > M_MAX)
            m_full = M_MAX;
        else
            m_full = seg3;
        s2_m_d = FP'(m_full);
    end

    always_ff @(posedge clock_i) begin
        if (s2_load && s1_v_q) begin
            s2_m_q    <= s2_m_d;
            s2_sign_q <= s1_sign_q;
            s2_mode_q <= s1_mode_q;
            s2_sat_q  <= s1_sat_q;
        end
    end

    // Stage 3: truncate to FO bits, then sign restore (tanh) or (1 +/- m)/2 (sigmoid).
    logic [FO-1:0]    m_fo;
    logic [W_OUT-1:0] mag, sig_sum, y_d, out_data_q;
    logic             out_sat_q;

    always_comb begin
        m_fo    = FO'(s2_m_q >> (FP - FO));
        mag     = {{OUT_I{1'b0}}, m_fo};
        sig_sum = s2_sign_q ? ((W_OUT'(1) << FO) - mag) : ((W_OUT'(1) << FO) + mag);
        if (s2_mode_q)
            y_d = sig_sum >> 1;
        else
            y_d = s2_sign_q ? (~mag + W_OUT'(1)) : mag;
    end

    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            out_data_q <= '0;
            out_sat_q  <= 1'b0;
        end else if (s3_load && s2_v_q) begin
            out_data_q <= y_d;
            out_sat_q  <= s2_sat_q;
        end
    end

    assign out_valid_o = s3_v_q;
    assign out_data_o  = out_data_q;
    assign out_sat_o   = out_sat_q;
endmodule
